// File: rtl/dcache_arb_pkg.sv
// Shared types and default widths for the data-cache SRAM port arbiter.
package dcache_arb_pkg;

   localparam int DEF_ADDR_W = 12;
   localparam int DEF_DATA_W = 32;
   localparam int DEF_MASK_W = DEF_DATA_W / 8;

   // Widths follow the package defaults; the arbiter top uses the same defaults.
   typedef struct packed {
      logic                  wr;
      logic [DEF_ADDR_W-1:0] addr;
      logic [DEF_DATA_W-1:0] wdata;
      logic [DEF_MASK_W-1:0] mask;
   } mem_req_t;

   typedef enum logic [1:0] {
      OWN_IDLE = 2'd0,
      OWN_P0   = 2'd1,
      OWN_P1   = 2'd2
   } own_e;

endpackage

// File: rtl/dcache_arb_pick.sv
// Combinational grant selection for the two SRAM requesters.
// DCACHE_ARB_RR_EN selects round-robin; otherwise fixed priority with a starvation override.
module dcache_arb_pick (
   input  logic req0_i,
   input  logic req1_i,
   input  logic last_gnt_i,
   input  logic starve_hit_i,
   output logic gnt0_o,
   output logic gnt1_o
);

`ifdef DCACHE_ARB_RR_EN
   logic unused_starve_hit_s;
   assign unused_starve_hit_s = starve_hit_i;

   // On conflict the port that did not win last time is served.
   always_comb begin
      gnt0_o = 1'b0;
      gnt1_o = 1'b0;
      if (req0_i && req1_i) begin
         if (last_gnt_i) begin
            gnt0_o = 1'b1;
         end else begin
            gnt1_o = 1'b1;
         end
      end else if (req0_i) begin
         gnt0_o = 1'b1;
      end else if (req1_i) begin
         gnt1_o = 1'b1;
      end else begin
         gnt0_o = 1'b0;
         gnt1_o = 1'b0;
      end
   end
`else
   logic unused_last_gnt_s;
   assign unused_last_gnt_s = last_gnt_i;

   // Port 0 wins unless port 1 has been starved long enough.
   always_comb begin
      gnt0_o = 1'b0;
      gnt1_o = 1'b0;
      if (req1_i && starve_hit_i) begin
         gnt1_o = 1'b1;
      end else if (req0_i) begin
         gnt0_o = 1'b1;
      end else if (req1_i) begin
         gnt1_o = 1'b1;
      end else begin
         gnt0_o = 1'b0;
         gnt1_o = 1'b0;
      end
   end
`endif

endmodule

// File: rtl/dcache_port_arbiter.sv
// Shares the single-port data SRAM between the LSU (port 0) and the DMA/loader (port 1).
// Build with DCACHE_ARB_RR_EN for round-robin arbitration instead of fixed priority.
module dcache_port_arbiter
   import dcache_arb_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int MASK_W     = DATA_W / 8,
   parameter int STARVE_MAX = 8
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              req0_i,
   input  logic              wr0_i,
   input  logic [ADDR_W-1:0] addr0_i,
   input  logic [DATA_W-1:0] wdata0_i,
   input  logic [MASK_W-1:0] mask0_i,
   input  logic              req1_i,
   input  logic              wr1_i,
   input  logic [ADDR_W-1:0] addr1_i,
   input  logic [DATA_W-1:0] wdata1_i,
   input  logic [MASK_W-1:0] mask1_i,
   output logic              gnt0_o,
   output logic              gnt1_o,
   output logic              rvalid0_o,
   output logic [DATA_W-1:0] rdata0_o,
   output logic              rvalid1_o,
   output logic [DATA_W-1:0] rdata1_o,
   output logic              mem_en_o,
   output logic              mem_wr_en_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wr_data_o,
   output logic [MASK_W-1:0] mem_wr_mask_o,
   input  logic [DATA_W-1:0] mem_rd_data_i
);

   // Requests are masked during reset so no grant or SRAM access can escape.
   logic req0_v_s, req1_v_s, any_gnt_s, starve_hit_s;
   logic last_gnt_d, last_gnt_q;
   logic rd_pend_d, rd_pend_q, rd_owner_d, rd_owner_q;
   own_e own_d, own_q;
   mem_req_t req0_s, req1_s, sel_s;

   assign req0_v_s  = req0_i & rst_ni;
   assign req1_v_s  = req1_i & rst_ni;
   assign any_gnt_s = gnt0_o | gnt1_o;

   dcache_arb_pick u_pick (
      .req0_i       (req0_v_s),
      .req1_i       (req1_v_s),
      .last_gnt_i   (last_gnt_q),
      .starve_hit_i (starve_hit_s),
      .gnt0_o       (gnt0_o),
      .gnt1_o       (gnt1_o)
   );

`ifdef DCACHE_ARB_RR_EN
   assign starve_hit_s = 1'b0;
`else
   localparam int CNT_W = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] STARVE_MAX_C = CNT_W'(STARVE_MAX);
   logic [CNT_W-1:0] starve_d, starve_q;

   assign starve_hit_s = req1_v_s && (starve_q == STARVE_MAX_C);

   // Count consecutive cycles port 1 waits; saturate so the override stays armed.
   always_comb begin
      starve_d = starve_q;
      if (!req1_v_s || gnt1_o) begin
         starve_d = '0;
      end else if (starve_q != STARVE_MAX_C) begin
         starve_d = starve_q + CNT_W'(1);
      end else begin
         starve_d = starve_q;
      end
   end

   // Starvation counter register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end
`endif

   assign req0_s = '{wr: wr0_i, addr: addr0_i, wdata: wdata0_i, mask: mask0_i};
   assign req1_s = '{wr: wr1_i, addr: addr1_i, wdata: wdata1_i, mask: mask1_i};

   // SRAM request mux; idle cycles present an all-zero request.
   always_comb begin
      sel_s = '0;
      if (gnt1_o) begin
         sel_s = req1_s;
      end else if (gnt0_o) begin
         sel_s = req0_s;
      end else begin
         sel_s = '0;
      end
   end

   assign mem_en_o      = any_gnt_s;
   assign mem_wr_en_o   = any_gnt_s & sel_s.wr;
   assign mem_addr_o    = sel_s.addr;
   assign mem_wr_data_o = sel_s.wdata;
   assign mem_wr_mask_o = sel_s.mask;

   // Next-state for the grant history and read-return pipeline.
   always_comb begin
      last_gnt_d = last_gnt_q;
      rd_pend_d  = any_gnt_s & ~sel_s.wr;
      rd_owner_d = gnt1_o;
      if (any_gnt_s) begin
         last_gnt_d = gnt1_o;
      end else begin
         last_gnt_d = last_gnt_q;
      end
   end

   // Owner tracking is observational only; arbitration never reads it.
   always_comb begin
      own_d = own_q;
      case (own_q)
         OWN_IDLE, OWN_P0, OWN_P1: begin
            if (!(req0_v_s || req1_v_s)) begin
               own_d = OWN_IDLE;
            end else if (gnt0_o) begin
               own_d = OWN_P0;
            end else if (gnt1_o) begin
               own_d = OWN_P1;
            end else begin
               own_d = own_q;
            end
         end
         default: own_d = OWN_IDLE;
      endcase
   end

   // State registers; a read in flight at reset is discarded.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         last_gnt_q <= 1'b1;
         rd_pend_q  <= 1'b0;
         rd_owner_q <= 1'b0;
         own_q      <= OWN_IDLE;
      end else begin
         last_gnt_q <= last_gnt_d;
         rd_pend_q  <= rd_pend_d;
         rd_owner_q <= rd_owner_d;
         own_q      <= own_d;
      end
   end

   assign rvalid0_o = rd_pend_q & ~rd_owner_q;
   assign rvalid1_o = rd_pend_q &  rd_owner_q;
   assign rdata0_o  = mem_rd_data_i;
   assign rdata1_o  = mem_rd_data_i;

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Scoreboard bench for dcache_port_arbiter: directed scenarios followed by random traffic.
module tb_dcache_port_arbiter;

   localparam int AW = 12;
   localparam int DW = 32;
   localparam int MW = 4;
   localparam int STARVE = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n = 1'b0;
   logic req0 = 1'b0, wr0 = 1'b0, req1 = 1'b0, wr1 = 1'b0;
   logic [AW-1:0] addr0 = '0, addr1 = '0;
   logic [DW-1:0] wd0 = '0, wd1 = '0;
   logic [MW-1:0] m0 = '0, m1 = '0;
   logic gnt0, gnt1, rv0, rv1, men, mwe;
   logic [DW-1:0] rd0, rd1, mwd;
   logic [DW-1:0] mrd = '0;
   logic [AW-1:0] maddr;
   logic [MW-1:0] mwm;

   dcache_port_arbiter dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req0_i(req0), .wr0_i(wr0), .addr0_i(addr0), .wdata0_i(wd0), .mask0_i(m0),
      .req1_i(req1), .wr1_i(wr1), .addr1_i(addr1), .wdata1_i(wd1), .mask1_i(m1),
      .gnt0_o(gnt0), .gnt1_o(gnt1),
      .rvalid0_o(rv0), .rdata0_o(rd0), .rvalid1_o(rv1), .rdata1_o(rd1),
      .mem_en_o(men), .mem_wr_en_o(mwe), .mem_addr_o(maddr),
      .mem_wr_data_o(mwd), .mem_wr_mask_o(mwm), .mem_rd_data_i(mrd)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Environment SRAM driven only by the DUT's memory interface.
   logic [DW-1:0] sram [0:(1<<AW)-1];
   always @(posedge clk) begin : sram_p
      logic [DW-1:0] w;
      if (men) begin
         if (mwe) begin
            w = sram[maddr];
            for (int b = 0; b < MW; b++) if (mwm[b]) w[8*b +: 8] = mwd[8*b +: 8];
            sram[maddr] <= w;
         end else begin
            mrd <= sram[maddr];
         end
      end
   end

   // Reference model state: expected memory image, starvation count, last winner.
   logic [DW-1:0] refm [0:(1<<AW)-1];
   int lost1 = 0;
   bit last = 1'b1;
   bit started = 1'b0;

   typedef struct {
      int cyc; bit g0; bit g1; bit en; bit we;
      logic [AW-1:0] addr; logic [DW-1:0] wd; logic [MW-1:0] mask;
   } acc_t;
   typedef struct { int cyc; bit port; logic [DW-1:0] data; } rd_t;
   acc_t acc_q[$];
   rd_t  rd_q[$];

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] init_word(input int a);
      logic [AW-1:0] aa;
      aa = AW'(a);
      return {aa, 4'hA, ~aa, 4'h5};
   endfunction

   // Predict this cycle's grant and memory access from the current inputs.
   task automatic predict(output bit g0, output bit g1);
      acc_t e;
      logic [DW-1:0] w;
      g0 = 1'b0; g1 = 1'b0;
      started = 1'b1;
      e = '{cyc: cyc, g0: 1'b0, g1: 1'b0, en: 1'b0, we: 1'b0, addr: '0, wd: '0, mask: '0};
      if (!rst_n) begin
         lost1 = 0; last = 1'b1;
         rd_q.delete();
      end else begin
         if (req0 && req1) begin
`ifdef DCACHE_ARB_RR_EN
            g0 = last; g1 = !last;
`else
            g1 = (lost1 >= STARVE); g0 = !g1;
`endif
         end else begin
            g0 = req0; g1 = req1;
         end
         if (req1 && !g1) lost1 = (lost1 < STARVE) ? lost1 + 1 : STARVE;
         else lost1 = 0;
         if (g0 || g1) begin
            last = g1;
            e.en = 1'b1;
            e.we = g1 ? wr1 : wr0;
            e.addr = g1 ? addr1 : addr0;
            e.wd = g1 ? wd1 : wd0;
            e.mask = g1 ? m1 : m0;
            if (e.we) begin
               w = refm[e.addr];
               for (int b = 0; b < MW; b++) if (e.mask[b]) w[8*b +: 8] = e.wd[8*b +: 8];
               refm[e.addr] = w;
            end else begin
               rd_q.push_back('{cyc: cyc + 1, port: g1, data: refm[e.addr]});
            end
         end
      end
      e.g0 = g0; e.g1 = g1;
      acc_q.push_back(e);
   endtask

   // Monitor: compare the DUT's outputs mid-cycle against the queued expectations.
   always @(negedge clk) begin
      acc_t e;
      bit ev0, ev1;
      if (started) begin
         if (acc_q.size() > 0) begin
            e = acc_q.pop_front();
            chk("sb_sync", 64'(e.cyc), 64'(cyc));
            chk("gnt0", 64'(gnt0), 64'(e.g0));
            chk("gnt1", 64'(gnt1), 64'(e.g1));
            chk("mem_en", 64'(men), 64'(e.en));
            chk("mem_wr_en", 64'(mwe), 64'(e.we));
            chk("mem_addr", 64'(maddr), 64'(e.addr));
            chk("mem_wr_data", 64'(mwd), 64'(e.wd));
            chk("mem_wr_mask", 64'(mwm), 64'(e.mask));
         end
         ev0 = (rd_q.size() > 0) && (rd_q[0].cyc == cyc) && !rd_q[0].port;
         ev1 = (rd_q.size() > 0) && (rd_q[0].cyc == cyc) && rd_q[0].port;
         chk("rvalid0", 64'(rv0), 64'(ev0));
         chk("rvalid1", 64'(rv1), 64'(ev1));
         if (ev0) chk("rdata0", 64'(rd0), 64'(rd_q[0].data));
         if (ev1) chk("rdata1", 64'(rd1), 64'(rd_q[0].data));
         if (ev0 || ev1) void'(rd_q.pop_front());
      end
   end

   task automatic cyc_begin();
      @(posedge clk);
      #1;
   endtask

   task automatic set0(input logic r, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [MW-1:0] m);
      req0 = r; wr0 = w; addr0 = a; wd0 = d; m0 = m;
   endtask

   task automatic set1(input logic r, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [MW-1:0] m);
      req1 = r; wr1 = w; addr1 = a; wd1 = d; m1 = m;
   endtask

   initial begin
      bit g0, g1, act0, act1;
      for (int i = 0; i < (1 << AW); i++) begin
         sram[i] = init_word(i);
         refm[i] = init_word(i);
      end

      // Reset with both ports requesting, then release idle.
      for (int i = 0; i < 3; i++) begin
         cyc_begin(); rst_n = 1'b0;
         set0(1'b1, 1'b0, 12'h001, 32'h0, 4'h0);
         set1(1'b1, 1'b0, 12'h002, 32'h0, 4'h0);
         predict(g0, g1);
      end
      for (int i = 0; i < 2; i++) begin
         cyc_begin(); rst_n = 1'b1;
         set0(1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
         set1(1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
         predict(g0, g1);
      end

      // Single read on port 0.
      cyc_begin(); set0(1'b1, 1'b0, 12'h010, 32'h0, 4'h0); predict(g0, g1);
      cyc_begin(); set0(1'b0, 1'b0, 12'h0, 32'h0, 4'h0); predict(g0, g1);

      // Port 1 write at the top address, then read it back.
      cyc_begin(); set1(1'b1, 1'b1, 12'hFFF, 32'hDEADBEEF, 4'b0101); predict(g0, g1);
      cyc_begin(); set1(1'b0, 1'b0, 12'h0, 32'h0, 4'h0); predict(g0, g1);
      cyc_begin(); set1(1'b1, 1'b0, 12'hFFF, 32'h0, 4'h0); predict(g0, g1);
      cyc_begin(); set1(1'b0, 1'b0, 12'h0, 32'h0, 4'h0); predict(g0, g1);

      // Sustained conflict: starvation override lets port 1 in on the ninth cycle.
      for (int i = 0; i < 20; i++) begin
         cyc_begin();
         set0(1'b1, 1'b0, 12'h030, 32'h0, 4'h0);
         set1(1'b1, 1'b0, 12'h040, 32'h0, 4'h0);
         predict(g0, g1);
      end
      cyc_begin();
      set0(1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
      set1(1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
      predict(g0, g1);

      // Back-to-back reads from alternating ports.
      cyc_begin(); set0(1'b1, 1'b0, 12'h011, 32'h0, 4'h0); predict(g0, g1);
      cyc_begin(); set0(1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
      set1(1'b1, 1'b0, 12'h012, 32'h0, 4'h0); predict(g0, g1);
      cyc_begin(); set1(1'b0, 1'b0, 12'h0, 32'h0, 4'h0); predict(g0, g1);

      // Reset the cycle after a read grant: the return must vanish.
      cyc_begin(); set0(1'b1, 1'b0, 12'h020, 32'h0, 4'h0); predict(g0, g1);
      cyc_begin(); rst_n = 1'b0; set0(1'b0, 1'b0, 12'h0, 32'h0, 4'h0); predict(g0, g1);
      cyc_begin(); predict(g0, g1);
      for (int i = 0; i < 3; i++) begin
         cyc_begin(); rst_n = 1'b1; predict(g0, g1);
      end

      // Random traffic; requests are held until granted or occasionally withdrawn.
      act0 = 1'b0; act1 = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         cyc_begin();
         if (!act0 && $urandom_range(0, 2) != 0) begin
            act0 = 1'b1; wr0 = 1'($urandom_range(0, 1)); addr0 = 12'($urandom_range(0, 63));
            wd0 = $urandom; m0 = 4'($urandom);
         end else if (act0 && $urandom_range(0, 15) == 0) begin
            act0 = 1'b0;
         end
         if (!act1 && $urandom_range(0, 2) != 0) begin
            act1 = 1'b1; wr1 = 1'($urandom_range(0, 1)); addr1 = 12'($urandom_range(0, 63));
            wd1 = $urandom; m1 = 4'($urandom);
         end else if (act1 && $urandom_range(0, 31) == 0) begin
            act1 = 1'b0;
         end
         rst_n = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
         req0 = act0; req1 = act1;
         predict(g0, g1);
         if (g0) act0 = 1'b0;
         if (g1) act1 = 1'b0;
      end

      for (int i = 0; i < 3; i++) begin
         cyc_begin(); rst_n = 1'b1; req0 = 1'b0; req1 = 1'b0; predict(g0, g1);
      end
      @(posedge clk); #1;
      chk("rd_drain", 64'(rd_q.size()), 64'd0);
      chk("acc_drain", 64'(acc_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
